memory_port_arbiter: RTL and testbench

//  Shares one single_port_memory_group between the fetch port (IF) and the load/store port (MEM) of the RV32E core.

---
 rtl/memory_port_arbiter.sv | 138 +++++++++++++
 tb/tb_memory_port_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter
//   Shares one single-port memory group between the fetch port (IF) and the
//   load/store port (MEM). Grants one request per cycle, tracks in-flight reads
//   through a 2-stage tag pipe and returns read data to the owning requester.
//   A saturating starvation counter forces an IF win after STARVE_LIMIT denials.
//   Optional performance counters: define MEM_ARB_PERF_EN to enable them.

`ifndef DATAWIDTH_BYTE
`define DATAWIDTH_BYTE  2'b00
`endif
`ifndef DATAWIDTH_SHORT
`define DATAWIDTH_SHORT 2'b01
`endif
`ifndef DATAWIDTH_WORD
`define DATAWIDTH_WORD  2'b10
`endif

module memory_port_arbiter #(
  parameter int unsigned DATA_DEPTH   = 4096,
  parameter int unsigned STARVE_LIMIT = 4,
  localparam int unsigned ADDR_W      = 2 + $clog2(DATA_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_width,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              mem_we,
  output logic [1:0]        mem_data_width,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data,
  output logic [31:0]       perf_if_stall,
  output logic [31:0]       perf_conflicts
);

  logic [3:0] starve_cnt;
  logic       starved;
  logic       s0_valid, s0_if;
  logic       s1_valid, s1_if;
  logic [1:0] d_width_eff;

  assign starved     = (starve_cnt == 4'(STARVE_LIMIT));
  assign d_width_eff = (d_width == 2'b11) ? `DATAWIDTH_WORD : d_width;

  // Grants are suppressed while reset is asserted so nothing reaches memory.
  assign if_gnt = ~rst & if_req & (~d_req | starved);
  assign d_gnt  = ~rst & d_req & (~if_req | ~starved);

  // Shared memory port mux; idle and IF cycles never write.
  always_comb begin
    mem_we         = 1'b0;
    mem_data_width = `DATAWIDTH_WORD;
    mem_addr       = '0;
    mem_write_data = '0;
    if (if_gnt) begin
      mem_addr = if_addr;
    end else if (d_gnt) begin
      mem_we         = d_we;
      mem_data_width = d_width_eff;
      mem_addr       = d_addr;
      mem_write_data = d_wdata;
    end
  end

  // Starvation counter: counts consecutive denied IF cycles, saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (if_req & ~if_gnt) begin
      if (!starved) starve_cnt <= starve_cnt + 4'd1;
    end else begin
      starve_cnt <= '0;
    end
  end

  // Read tag pipe: stage0 marks the cycle memory data is presented,
  // stage1 drives the rvalid pulse alongside the captured data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_valid <= 1'b0;
      s0_if    <= 1'b0;
      s1_valid <= 1'b0;
      s1_if    <= 1'b0;
    end else begin
      s0_valid <= if_gnt | (d_gnt & ~d_we);
      s0_if    <= if_gnt;
      s1_valid <= s0_valid;
      s1_if    <= s0_if;
    end
  end

  // Read data capture; each register holds until its owner's next read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_rdata <= '0;
      d_rdata  <= '0;
    end else if (s0_valid) begin
      if (s0_if) if_rdata <= mem_read_data;
      else       d_rdata  <= mem_read_data;
    end
  end

  assign if_rvalid = s1_valid & s1_if;
  assign d_rvalid  = s1_valid & ~s1_if;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] stall_q, conflict_q;

  // Free-running, wrapping performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q    <= '0;
      conflict_q <= '0;
    end else begin
      if (if_req & ~if_gnt) stall_q    <= stall_q + 32'd1;
      if (if_req & d_req)   conflict_q <= conflict_q + 32'd1;
    end
  end

  assign perf_if_stall  = stall_q;
  assign perf_conflicts = conflict_q;
`else
  assign perf_if_stall  = '0;
  assign perf_conflicts = '0;
`endif

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Scoreboard bench for memory_port_arbiter: the stimulus pushes the expected
// read return (owner, word, arrival cycle) at each read grant; a monitor pops
// and compares whenever either rvalid is high.
module tb_memory_port_arbiter;

  localparam int AW = 14;
  localparam logic [1:0] WORD = 2'b10;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, d_req, d_we;
  logic [AW-1:0] if_addr, d_addr;
  logic [1:0]    d_width;
  logic [31:0]   d_wdata;
  logic          if_gnt, if_rvalid, d_gnt, d_rvalid, mem_we;
  logic [31:0]   if_rdata, d_rdata, mem_write_data, mem_read_data;
  logic [1:0]    mem_data_width;
  logic [AW-1:0] mem_addr;
  logic [31:0]   perf_if_stall, perf_conflicts;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    bit          owner_if;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  memory_port_arbiter #(.DATA_DEPTH(4096), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_width(d_width), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_we(mem_we), .mem_data_width(mem_data_width), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .perf_if_stall(perf_if_stall), .perf_conflicts(perf_conflicts)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: synchronous read, write-first; word i preloaded with A000_0000+i.
  logic [31:0] mem [0:63];
  logic [5:0]  raddr;
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + i;
    raddr = '0;
  end
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:2]] <= mem_write_data;
    raddr <= mem_addr[7:2];
  end
  assign mem_read_data = mem[raddr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every rvalid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (if_rvalid && d_rvalid) chk("rvalid_exclusive", 32'd1, 32'd0);
    if (if_rvalid || d_rvalid) begin
      if (sb.size() == 0) begin
        chk("unexpected_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rv_owner_if", {31'd0, if_rvalid}, {31'd0, e.owner_if});
        chk("rv_data", if_rvalid ? if_rdata : d_rdata, e.data);
        chk("rv_cycle", cyc, e.cyc);
      end
    end
  end

  // One cycle of stimulus with expected grants and expected returned word.
  task automatic step(input logic ir, input logic [AW-1:0] ia,
                      input logic dr, input logic dwe, input logic [1:0] dw,
                      input logic [AW-1:0] da, input logic [31:0] wd,
                      input logic eig, input logic edg, input logic [31:0] edata);
    exp_t e;
    if_req = ir; if_addr = ia;
    d_req = dr; d_we = dwe; d_width = dw; d_addr = da; d_wdata = wd;
    @(negedge clk);
    chk("if_gnt", {31'd0, if_gnt}, {31'd0, eig});
    chk("d_gnt", {31'd0, d_gnt}, {31'd0, edg});
    chk("mem_we", {31'd0, mem_we}, {31'd0, edg & dwe});
    chk("mem_addr", {18'd0, mem_addr}, {18'd0, eig ? ia : (edg ? da : 14'd0)});
    chk("mem_width", {30'd0, mem_data_width},
        {30'd0, (edg && !eig) ? ((dw == 2'b11) ? WORD : dw) : WORD});
    chk("mem_wdata", mem_write_data, (edg && !eig) ? wd : 32'd0);
    if (eig || (edg && !dwe)) begin
      e.owner_if = eig; e.data = edata; e.cyc = cyc + 2;
      sb.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, 0, WORD, '0, '0, 0, 0, '0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_if_gnt", {31'd0, if_gnt}, 32'd0);
    chk("rst_d_gnt", {31'd0, d_gnt}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_if_rvalid", {31'd0, if_rvalid}, 32'd0);
    chk("rst_d_rvalid", {31'd0, d_rvalid}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_perf_stall", perf_if_stall, 32'd0);
    chk("rst_perf_conf", perf_conflicts, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with requests (including a store) active: nothing may be granted.
    rst = 1'b1;
    if_req = 1; if_addr = 14'h4; d_req = 1; d_we = 1; d_width = WORD;
    d_addr = 14'h8; d_wdata = 32'h1111_2222;
    repeat (2) @(negedge clk);
    chk_reset_outputs();
    @(posedge clk); #1;
    rst = 1'b0;

    // IF-only back-to-back reads.
    step(1, 14'h0, 0, 0, WORD, '0, '0, 1, 0, 32'hA000_0000);
    step(1, 14'h4, 0, 0, WORD, '0, '0, 1, 0, 32'hA000_0001);
    step(1, 14'h8, 0, 0, WORD, '0, '0, 1, 0, 32'hA000_0002);
    // Idle with junk on the address/data inputs: mem port at defaults.
    step(0, 14'h123c, 0, 1, 2'b01, 14'h0abc, 32'h1234_5678, 0, 0, '0);
    idle(3);

    // Conflict: MEM wins 4 times, IF forced on the 5th, then MEM again.
    for (int i = 0; i < 6; i++)
      step(1, 14'h40, 1, 0, WORD, 14'h10, '0, i == 4, i != 4,
           (i == 4) ? 32'hA000_0010 : 32'hA000_0004);
    idle(3);

    // Store then load (width 2'b11 treated as word) to the same address.
    step(0, '0, 1, 1, WORD, 14'h21, 32'hDEAD_BEEF, 0, 1, '0);
    step(0, '0, 1, 0, 2'b11, 14'h21, '0, 0, 1, 32'hDEAD_BEEF);
    idle(3);

    // Interleaved IF read then MEM load; also a byte load.
    step(1, 14'h8, 0, 0, WORD, '0, '0, 1, 0, 32'hA000_0002);
    step(0, '0, 1, 0, 2'b00, 14'h11, '0, 0, 1, 32'hA000_0004);
    idle(3);

    // Reset one cycle after a load grant: the in-flight read is dropped.
    step(0, '0, 1, 0, WORD, 14'h10, '0, 0, 1, 32'hA000_0004);
    void'(sb.pop_back());
    rst = 1'b1;
    if_req = 1; d_req = 1; d_we = 1;
    @(negedge clk);
    chk_reset_outputs();
    @(posedge clk); #1;
    @(negedge clk);
    chk_reset_outputs();
    @(posedge clk); #1;
    rst = 1'b0;
    idle(4);

    // Ten conflict cycles for the performance counters.
    for (int i = 0; i < 10; i++)
      step(1, 14'h40, 1, 0, WORD, 14'h10, '0, (i % 5) == 4, (i % 5) != 4,
           ((i % 5) == 4) ? 32'hA000_0010 : 32'hA000_0004);
    idle(3);
    @(negedge clk);
`ifdef MEM_ARB_PERF_EN
    chk("perf_conflicts", perf_conflicts, 32'd10);
    chk("perf_if_stall", perf_if_stall, 32'd8);
`else
    chk("perf_conflicts", perf_conflicts, 32'd0);
    chk("perf_if_stall", perf_if_stall, 32'd0);
`endif
    chk("sb_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
